// File: rtl/oen4bit_reg.sv
// Clocked holding register with output enable for shared output buses.
// Define OEN4BIT_TRISTATE_EN to float data_out (z) when disabled; otherwise it is driven low.

module oen4bit_reg_bit #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  input  logic oen,
  output logic y
);
  logic q_d, q_q;

  always_comb begin
    q_d = d;
    if (clr) q_d = RST_BIT;
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  // Enable only gates the output path; capture continues regardless.
`ifdef OEN4BIT_TRISTATE_EN
  assign y = oen ? q_q : 1'bz;
`else
  assign y = oen ? q_q : 1'b0;
`endif
endmodule

module oen4bit_reg #(
  parameter int unsigned      WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] data_in,
  input  logic             Oen,
  output logic [WIDTH-1:0] data_out
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    oen4bit_reg_bit #(
      .RST_BIT (RESET_VALUE[i])
    ) u_bit (
      .clk (clk),
      .clr (clr),
      .d   (data_in[i]),
      .oen (Oen),
      .y   (data_out[i])
    );
  end
endmodule

// File: tb/tb_oen4bit_reg.sv
// Directed bench for oen4bit_reg: vector table plus hand sequences for combinational Oen and glitches.

module tb_oen4bit_reg;
  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] data_in = 4'b0000;
  logic       Oen = 1'b0;
  logic [3:0] data_out;

  int errors = 0;
  int checks = 0;

  logic [3:0] dis;

  typedef struct {
    logic       clr;
    logic       oen;
    logic [3:0] din;
    logic [3:0] exp;
    logic       exp_dis;
  } vec_t;

  oen4bit_reg #(.WIDTH(4), .RESET_VALUE(4'b0000)) dut (
    .clk      (clk),
    .clr      (clr),
    .data_in  (data_in),
    .Oen      (Oen),
    .data_out (data_out)
  );

  always #50 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic [3:0] e;
    @(negedge clk);
    clr = v.clr; Oen = v.oen; data_in = v.din;
    @(posedge clk);
    #10;
    e = v.exp_dis ? dis : v.exp;
    check($sformatf("vec%0d", idx), data_out, e);
  endtask

  vec_t t1 [3];
  vec_t t2 [4];
  vec_t t3 [3];

  initial begin
`ifdef OEN4BIT_TRISTATE_EN
    dis = 4'bzzzz;
`else
    dis = 4'b0000;
`endif
    // T1 reset, T2 capture while disabled
    t1[0] = '{clr:1'b1, oen:1'b1, din:4'b1111, exp:4'b0000, exp_dis:1'b0};
    t1[1] = '{clr:1'b0, oen:1'b0, din:4'b0011, exp:4'b0000, exp_dis:1'b1};
    t1[2] = '{clr:1'b0, oen:1'b0, din:4'b1010, exp:4'b0000, exp_dis:1'b1};
    // T3 tail and T4 pass-through
    t2[0] = '{clr:1'b0, oen:1'b1, din:4'b1111, exp:4'b1111, exp_dis:1'b0};
    t2[1] = '{clr:1'b0, oen:1'b1, din:4'b1001, exp:4'b1001, exp_dis:1'b0};
    t2[2] = '{clr:1'b0, oen:1'b1, din:4'b0011, exp:4'b0011, exp_dis:1'b0};
    t2[3] = '{clr:1'b0, oen:1'b1, din:4'b1010, exp:4'b1010, exp_dis:1'b0};
    // T5 mid-stream clear and release
    t3[0] = '{clr:1'b1, oen:1'b1, din:4'b1111, exp:4'b0000, exp_dis:1'b0};
    t3[1] = '{clr:1'b1, oen:1'b1, din:4'b1001, exp:4'b0000, exp_dis:1'b0};
    t3[2] = '{clr:1'b0, oen:1'b1, din:4'b1001, exp:4'b1001, exp_dis:1'b0};

    for (int i = 0; i < 3; i++) apply(t1[i], i);

    // Raising Oen mid-cycle shows the last capture at once.
    @(negedge clk);
    Oen = 1'b1;
    #1 check("oen_rise_shows_last", data_out, 4'b1010);

    for (int i = 0; i < 4; i++) apply(t2[i], 10 + i);

    // data_in glitch between edges is invisible; restore before the edge.
    @(negedge clk);
    data_in = 4'b0101;
    #5 check("glitch_hidden_a", data_out, 4'b1010);
    data_in = 4'b1100;
    #5 check("glitch_hidden_b", data_out, 4'b1010);
    data_in = 4'b1010;
    @(posedge clk); #10;
    check("glitch_after_edge", data_out, 4'b1010);

    // T6: Oen toggle with q=1010, combinational in both directions.
    @(negedge clk);
    Oen = 1'b0;
    #1 check("toggle_off", data_out, dis);
    #5 Oen = 1'b1;
    #1 check("toggle_on", data_out, 4'b1010);

    for (int i = 0; i < 3; i++) apply(t3[i], 20 + i);

    // Capture continues while disabled.
    @(negedge clk);
    Oen = 1'b0; data_in = 4'b0110;
    @(posedge clk); #10;
    check("disabled_after_load", data_out, dis);
    @(negedge clk);
    data_in = 4'b0001;
    Oen = 1'b1;
    #1 check("load_while_disabled", data_out, 4'b0110);
    @(posedge clk); #10;
    check("resume_load", data_out, 4'b0001);

    // Clear while disabled, then enable shows RESET_VALUE.
    @(negedge clk);
    Oen = 1'b0; clr = 1'b1; data_in = 4'b1110;
    @(posedge clk); #10;
    check("clr_disabled", data_out, dis);
    Oen = 1'b1;
    #1 check("clr_then_enable", data_out, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got hang expected finish");
    $fatal(1, "timeout");
  end
endmodule
